// File: rtl/dac_gate_meas.sv
// dac_gate_meas: receive-side monitor for the triggered DAC clock gate.
// Mirrors the generator's elapsed counter, measures the trigger-to-gate delay
// and the gate width for every trigger, and keeps sticky error flags for the
// register bank (diagnostics and interlock).
module dac_gate_meas #(
  parameter int CNT_W     = 11,
  parameter int TIMEOUT   = 1000,
  parameter int EXP_WIDTH = 711,
  parameter int WIDTH_TOL = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig,
  input  logic             gate_in,
  input  logic [CNT_W-1:0] exp_dly,
  input  logic             err_clr,
  output logic             busy,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_dly,
  output logic [CNT_W-1:0] meas_width,
  output logic             err_no_gate,
  output logic             err_dly,
  output logic             err_width,
  output logic             err_retrig,
  output logic [15:0]      trig_cnt
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    WAIT_RISE = 3'd2,
    HIGH      = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0]        TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]        WIDTH_MAX = '1;
  localparam logic signed [CNT_W:0]   EXP_W_S   = (CNT_W+1)'(EXP_WIDTH);
  localparam logic signed [CNT_W:0]   TOL_S     = (CNT_W+1)'(WIDTH_TOL);

  state_t           state_reg;
  logic [CNT_W-1:0] elapsed_reg;
  logic [CNT_W-1:0] dly_cap_reg;   // delay of the measurement in progress
  logic [CNT_W-1:0] width_reg;     // gate-high samples counted so far
  logic             no_gate_reg;   // last published result was a no-gate timeout

  logic [CNT_W-1:0]      width_inc;
  logic signed [CNT_W:0] width_dev;
  logic                  width_bad;
  logic                  dly_bad;
  logic                  at_timeout;

  assign at_timeout = (elapsed_reg == TIMEOUT_C);
  assign width_inc  = (width_reg == WIDTH_MAX) ? width_reg : width_reg + 1'b1;

  // Deviation of the published width from nominal, one extra bit so the
  // difference is signed and cannot wrap.
  assign width_dev = $signed({1'b0, meas_width}) - EXP_W_S;
  assign width_bad = (width_dev > TOL_S) || (width_dev < -TOL_S);
  assign dly_bad   = (meas_dly != exp_dly);

  assign busy = (state_reg == WAIT_RISE) || (state_reg == HIGH);

  // Elapsed counter identical to the generator: cleared by trig, saturates at TIMEOUT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      elapsed_reg <= '0;
    end else if (trig) begin
      elapsed_reg <= '0;
    end else if (!at_timeout) begin
      elapsed_reg <= elapsed_reg + 1'b1;
    end
  end

  // Measurement FSM with registered results, sticky flags and trigger count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      dly_cap_reg <= '0;
      width_reg   <= '0;
      no_gate_reg <= 1'b0;
      meas_valid  <= 1'b0;
      meas_dly    <= '0;
      meas_width  <= '0;
      err_no_gate <= 1'b0;
      err_dly     <= 1'b0;
      err_width   <= 1'b0;
      err_retrig  <= 1'b0;
      trig_cnt    <= '0;
    end else begin
      meas_valid <= 1'b0;

      // Clear first so that a set later in this block takes priority.
      if (err_clr) begin
        err_no_gate <= 1'b0;
        err_dly     <= 1'b0;
        err_width   <= 1'b0;
        err_retrig  <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (trig) begin
            state_reg <= ARM;
            trig_cnt  <= trig_cnt + 16'd1;
          end
        end

        ARM: begin
          // Last ARM cycle is the elapsed==0 sample: catches a zero start delay.
          if (!trig) begin
            if (gate_in) begin
              dly_cap_reg <= '0;
              width_reg   <= {{(CNT_W-1){1'b0}}, 1'b1};
              state_reg   <= HIGH;
            end else begin
              state_reg <= WAIT_RISE;
            end
          end
        end

        WAIT_RISE: begin
          if (trig) begin
            err_retrig <= 1'b1;
            trig_cnt   <= trig_cnt + 16'd1;
            state_reg  <= ARM;
          end else if (gate_in) begin
            dly_cap_reg <= elapsed_reg;
            width_reg   <= {{(CNT_W-1){1'b0}}, 1'b1};
            state_reg   <= HIGH;
          end else if (at_timeout) begin
            err_no_gate <= 1'b1;
            meas_dly    <= TIMEOUT_C;
            meas_width  <= '0;
            no_gate_reg <= 1'b1;
            meas_valid  <= 1'b1;
            state_reg   <= DONE;
          end
        end

        HIGH: begin
          if (trig) begin
            err_retrig <= 1'b1;
            trig_cnt   <= trig_cnt + 16'd1;
            state_reg  <= ARM;
          end else if (!gate_in) begin
            meas_dly    <= dly_cap_reg;
            meas_width  <= width_reg;
            no_gate_reg <= 1'b0;
            meas_valid  <= 1'b1;
            state_reg   <= DONE;
          end else if (at_timeout) begin
            // Gate stuck high: the current high sample is included in the width.
            meas_dly    <= dly_cap_reg;
            meas_width  <= width_inc;
            err_width   <= 1'b1;
            no_gate_reg <= 1'b0;
            meas_valid  <= 1'b1;
            state_reg   <= DONE;
          end else begin
            width_reg <= width_inc;
          end
        end

        DONE: begin
          // A no-gate timeout has no meaningful delay to compare.
          if (!no_gate_reg && dly_bad) begin
            err_dly <= 1'b1;
          end
          if (width_bad) begin
            err_width <= 1'b1;
          end
          if (trig) begin
            state_reg <= ARM;
            trig_cnt  <= trig_cnt + 16'd1;
          end else begin
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_gate_meas.sv
// Directed testbench for dac_gate_meas. The bench runs its own copy of the
// generator's elapsed counter and drives gate_in from a [g_start, g_stop] window.
module tb_dac_gate_meas;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        trig = 1'b0;
  logic        gate_in = 1'b0;
  logic [10:0] exp_dly = '0;
  logic        err_clr = 1'b0;
  logic        busy, meas_valid;
  logic [10:0] meas_dly, meas_width;
  logic        err_no_gate, err_dly, err_width, err_retrig;
  logic [15:0] trig_cnt;

  int checks = 0;
  int errors = 0;
  int el = 0;
  int g_start = 5000;
  int g_stop = 5000;
  int cyc = 0;
  int vcnt = 0;
  int last_valid_cyc = 0;
  int trig_cyc = 0;

  dac_gate_meas dut (
    .clk(clk), .reset(reset), .trig(trig), .gate_in(gate_in), .exp_dly(exp_dly),
    .err_clr(err_clr), .busy(busy), .meas_valid(meas_valid), .meas_dly(meas_dly),
    .meas_width(meas_width), .err_no_gate(err_no_gate), .err_dly(err_dly),
    .err_width(err_width), .err_retrig(err_retrig), .trig_cnt(trig_cnt)
  );

  always #4 clk = ~clk;

  // One clock: generator counter model, gate drive and meas_valid bookkeeping.
  task automatic step();
    logic t;
    t = trig;
    @(posedge clk);
    cyc++;
    if (t) el = 0;
    else if (el < 1000) el++;
    #1;
    gate_in = (el >= g_start) && (el <= g_stop);
    if (meas_valid === 1'b1) begin
      vcnt++;
      last_valid_cyc = cyc;
    end
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    step();
    trig_cyc = cyc;
    trig = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, input string name);
    int v0;
    v0 = vcnt;
    for (int i = 0; i < maxc && vcnt == v0; i++) step();
    checks++;
    if (vcnt == v0) begin
      errors++;
      $display("FAIL %s_valid: meas_valid not seen within %0d cycles", name, maxc);
    end else begin
      $display("meas %s: dly=%0d width=%0d latency=%0d trig_cnt=%0d",
               name, meas_dly, meas_width, last_valid_cyc - trig_cyc, trig_cnt);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(); step(); step();
    checks++;
    if ({busy, meas_valid, meas_dly, meas_width, err_no_gate, err_dly, err_width, err_retrig, trig_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b valid=%b dly=%0d width=%0d flags=%b%b%b%b cnt=%0d required all 0",
               busy, meas_valid, meas_dly, meas_width, err_no_gate, err_dly, err_width, err_retrig, trig_cnt);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_nominal();
    exp_dly = 11'd100; g_start = 100; g_stop = 810;
    pulse_trig();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL nominal_busy_arm: got %b required 0", busy); end
    step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL nominal_busy_wait: got %b required 1", busy); end
    wait_valid(1200, "nominal");
    checks++;
    if (last_valid_cyc - trig_cyc != 812) begin errors++; $display("FAIL nominal_latency: got %0d required 812", last_valid_cyc - trig_cyc); end
    checks++;
    if (meas_dly !== 11'd100) begin errors++; $display("FAIL nominal_dly: got %0d required 100", meas_dly); end
    checks++;
    if (meas_width !== 11'd711) begin errors++; $display("FAIL nominal_width: got %0d required 711", meas_width); end
    step();
    checks++;
    if (meas_valid !== 1'b0) begin errors++; $display("FAIL nominal_one_pulse: got %b required 0", meas_valid); end
    step();
    checks++;
    if ({err_no_gate, err_dly, err_width, err_retrig} !== 4'b0000) begin errors++; $display("FAIL nominal_flags: got %b%b%b%b required 0000", err_no_gate, err_dly, err_width, err_retrig); end
    checks++;
    if (trig_cnt !== 16'd1) begin errors++; $display("FAIL nominal_trig_cnt: got %0d required 1", trig_cnt); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL nominal_busy_idle: got %b required 0", busy); end
  endtask

  task automatic test_zero_delay();
    exp_dly = 11'd0; g_start = 0; g_stop = 710;
    pulse_trig();
    wait_valid(1200, "zero_dly");
    checks++;
    if (last_valid_cyc - trig_cyc != 712) begin errors++; $display("FAIL zero_latency: got %0d required 712", last_valid_cyc - trig_cyc); end
    checks++;
    if (meas_dly !== 11'd0) begin errors++; $display("FAIL zero_dly: got %0d required 0", meas_dly); end
    checks++;
    if (meas_width !== 11'd711) begin errors++; $display("FAIL zero_width: got %0d required 711", meas_width); end
    step(); step();
    checks++;
    if ({err_no_gate, err_dly, err_width, err_retrig} !== 4'b0000) begin errors++; $display("FAIL zero_flags: got %b%b%b%b required 0000", err_no_gate, err_dly, err_width, err_retrig); end
  endtask

  task automatic test_stuck_high();
    exp_dly = 11'd400; g_start = 400; g_stop = 99999;
    pulse_trig();
    wait_valid(1200, "stuck_high");
    checks++;
    if (last_valid_cyc - trig_cyc != 1001) begin errors++; $display("FAIL stuck_latency: got %0d required 1001", last_valid_cyc - trig_cyc); end
    checks++;
    if (meas_width !== 11'd601) begin errors++; $display("FAIL stuck_width: got %0d required 601", meas_width); end
    checks++;
    if (meas_dly !== 11'd400) begin errors++; $display("FAIL stuck_dly: got %0d required 400", meas_dly); end
    step(); step();
    checks++;
    if ({err_no_gate, err_dly, err_width, err_retrig} !== 4'b0010) begin errors++; $display("FAIL stuck_flags: got %b%b%b%b required 0010", err_no_gate, err_dly, err_width, err_retrig); end
    clear_errors();
    checks++;
    if (err_width !== 1'b0) begin errors++; $display("FAIL stuck_clear: got %b required 0", err_width); end
    g_start = 5000; g_stop = 5000;
  endtask

  task automatic test_no_gate_and_dly();
    exp_dly = 11'd50; g_start = 5000; g_stop = 5000;
    pulse_trig();
    wait_valid(1200, "no_gate");
    checks++;
    if (last_valid_cyc - trig_cyc != 1001) begin errors++; $display("FAIL nogate_latency: got %0d required 1001", last_valid_cyc - trig_cyc); end
    checks++;
    if (meas_width !== 11'd0) begin errors++; $display("FAIL nogate_width: got %0d required 0", meas_width); end
    checks++;
    if (meas_dly !== 11'd1000) begin errors++; $display("FAIL nogate_dly: got %0d required 1000", meas_dly); end
    step(); step();
    checks++;
    if (err_no_gate !== 1'b1) begin errors++; $display("FAIL nogate_flag: got %b required 1", err_no_gate); end
    checks++;
    if (err_dly !== 1'b0) begin errors++; $display("FAIL nogate_no_dly_err: got %b required 0", err_dly); end
    clear_errors();
    checks++;
    if ({err_no_gate, err_dly, err_width, err_retrig} !== 4'b0000) begin errors++; $display("FAIL nogate_clear: got %b%b%b%b required 0000", err_no_gate, err_dly, err_width, err_retrig); end
    // Gate starts two cycles late against the expected delay.
    g_start = 52; g_stop = 762;
    pulse_trig();
    wait_valid(1200, "late_gate");
    checks++;
    if (meas_dly !== 11'd52) begin errors++; $display("FAIL late_dly: got %0d required 52", meas_dly); end
    checks++;
    if (meas_width !== 11'd711) begin errors++; $display("FAIL late_width: got %0d required 711", meas_width); end
    step(); step();
    checks++;
    if ({err_no_gate, err_dly, err_width, err_retrig} !== 4'b0100) begin errors++; $display("FAIL late_flags: got %b%b%b%b required 0100", err_no_gate, err_dly, err_width, err_retrig); end
  endtask

  task automatic test_retrigger();
    int v0;
    do_reset();
    exp_dly = 11'd100; g_start = 100; g_stop = 810;
    pulse_trig();
    for (int i = 0; i < 400 && el != 300; i++) step();
    v0 = vcnt;
    trig = 1'b1;
    step();
    trig_cyc = cyc;
    trig = 1'b0;
    checks++;
    if (err_retrig !== 1'b1) begin errors++; $display("FAIL retrig_flag: got %b required 1", err_retrig); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL retrig_busy_arm: got %b required 0", busy); end
    wait_valid(1200, "retrig");
    checks++;
    if (vcnt - v0 != 1) begin errors++; $display("FAIL retrig_valid_count: got %0d required 1", vcnt - v0); end
    checks++;
    if (last_valid_cyc - trig_cyc != 812) begin errors++; $display("FAIL retrig_latency: got %0d required 812", last_valid_cyc - trig_cyc); end
    checks++;
    if (meas_dly !== 11'd100 || meas_width !== 11'd711) begin errors++; $display("FAIL retrig_result: got dly=%0d width=%0d required 100/711", meas_dly, meas_width); end
    checks++;
    if (trig_cnt !== 16'd2) begin errors++; $display("FAIL retrig_trig_cnt: got %0d required 2", trig_cnt); end
    step(); step();
    checks++;
    if ({err_no_gate, err_dly, err_width} !== 3'b000) begin errors++; $display("FAIL retrig_other_flags: got %b%b%b required 000", err_no_gate, err_dly, err_width); end
  endtask

  task automatic test_reset_mid_gate();
    int v0;
    exp_dly = 11'd100; g_start = 100; g_stop = 810;
    pulse_trig();
    for (int i = 0; i < 400 && el != 200; i++) step();
    v0 = vcnt;
    reset = 1'b0;
    step();
    checks++;
    if ({busy, meas_valid, meas_dly, meas_width, err_no_gate, err_dly, err_width, err_retrig, trig_cnt} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%b valid=%b dly=%0d width=%0d flags=%b%b%b%b cnt=%0d required all 0",
               busy, meas_valid, meas_dly, meas_width, err_no_gate, err_dly, err_width, err_retrig, trig_cnt);
    end
    reset = 1'b1;
    for (int i = 0; i < 700; i++) step();
    checks++;
    if (vcnt != v0) begin errors++; $display("FAIL midreset_no_valid: got %0d pulses required 0", vcnt - v0); end
    pulse_trig();
    wait_valid(1200, "after_reset");
    checks++;
    if (meas_dly !== 11'd100 || meas_width !== 11'd711) begin errors++; $display("FAIL midreset_result: got dly=%0d width=%0d required 100/711", meas_dly, meas_width); end
    checks++;
    if (trig_cnt !== 16'd1) begin errors++; $display("FAIL midreset_trig_cnt: got %0d required 1", trig_cnt); end
  endtask

  // Trigger on the DONE cycle itself must start a fresh measurement without a retrigger error.
  task automatic test_back_to_back();
    trig = 1'b1;
    step();
    trig_cyc = cyc;
    trig = 1'b0;
    checks++;
    if (trig_cnt !== 16'd2) begin errors++; $display("FAIL b2b_trig_cnt: got %0d required 2", trig_cnt); end
    wait_valid(1200, "back_to_back");
    checks++;
    if (last_valid_cyc - trig_cyc != 812) begin errors++; $display("FAIL b2b_latency: got %0d required 812", last_valid_cyc - trig_cyc); end
    checks++;
    if (meas_dly !== 11'd100 || meas_width !== 11'd711) begin errors++; $display("FAIL b2b_result: got dly=%0d width=%0d required 100/711", meas_dly, meas_width); end
    step(); step();
    checks++;
    if ({err_no_gate, err_dly, err_width, err_retrig} !== 4'b0000) begin errors++; $display("FAIL b2b_flags: got %b%b%b%b required 0000", err_no_gate, err_dly, err_width, err_retrig); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_delay();
    test_stuck_high();
    test_no_gate_and_dly();
    test_retrigger();
    test_reset_mid_gate();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
